// File: rtl/scmp_bus_pak.sv
// Shared types and constants for the SC/MP external bus cycle controller.
// The address-phase status byte carries flags in the upper nibble, A[15:12] below.
package scmp_bus_pak;

  localparam int BUS_ADDR_W  = 16;
  localparam int BUS_EXT_A_W = 12;

  localparam int FLAG_R_POS = 4;
  localparam int FLAG_I_POS = 5;
  localparam int FLAG_D_POS = 6;
  localparam int FLAG_H_POS = 7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARB  = 3'd1,
    ADDR = 3'd2,
    STRB = 3'd3,
    END  = 3'd4
  } BUS_STATE_t;

  function automatic logic [7:0] status_byte(input logic f_h, input logic f_d,
                                             input logic f_i, input logic f_r,
                                             input logic [3:0] a_hi);
    logic [7:0] b;
    b = {4'h0, a_hi};
    b[FLAG_R_POS] = f_r;
    b[FLAG_I_POS] = f_i;
    b[FLAG_D_POS] = f_d;
    b[FLAG_H_POS] = f_h;
    return b;
  endfunction

endpackage

// File: rtl/scmp_bus_arb.sv
// Daisy-chain bus arbitration: BREQ while arbitrating, grant on ENIN,
// and ENIN passed down the chain only when this master is idle with no request.
module scmp_bus_arb (
  input  logic rst_n,
  input  logic in_arb_i,
  input  logic idle_free_i,
  input  logic ext_ENIN,
  output logic ext_BREQ,
  output logic ext_ENOUT,
  output logic grant_o
);

  assign ext_BREQ  = in_arb_i;
  assign grant_o   = in_arb_i & ext_ENIN;
  assign ext_ENOUT = rst_n & ext_ENIN & idle_free_i;

endmodule

// File: rtl/scmp_bus_ctl.sv
// SC/MP external bus cycle controller: IDLE -> [ARB] -> ADDR -> STRB -> END.
// Arbitration (ARB state, BREQ/ENIN/ENOUT) is present only when SCMP_BUS_ARB_EN is defined.
module scmp_bus_ctl
  import scmp_bus_pak::*;
#(
  parameter int STROBE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bus_ADS_n,
  input  logic                   bus_RD_n,
  input  logic                   bus_WR_n,
  input  logic                   bus_F_R,
  input  logic                   bus_F_I,
  input  logic                   bus_F_D,
  input  logic                   bus_F_H,
  input  logic [BUS_ADDR_W-1:0]  addr_i,
  input  logic [7:0]             wdata_i,
  output logic                   stall,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  output logic [BUS_EXT_A_W-1:0] ext_A,
  input  logic [7:0]             ext_D_i,
  output logic [7:0]             ext_D_o,
  output logic                   ext_D_oe,
  output logic                   ext_NADS_n,
  output logic                   ext_NRDS_n,
  output logic                   ext_NWDS_n,
  input  logic                   ext_NHOLD_n,
  output logic                   ext_BREQ,
  input  logic                   ext_ENIN,
  output logic                   ext_ENOUT,
  output logic [2:0]             dbg_state_o
);

  localparam int CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_CYCLES - 1);

  BUS_STATE_t              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BUS_EXT_A_W-1:0]  ext_a_q;
  logic [7:0]              dout_q;
  logic [7:0]              wdata_q;
  logic [7:0]              rd_data_q;
  logic                    is_rd_q;
  logic                    is_wr_q;
  logic                    req;
  logic                    accept;
  logic                    grant;

  // Handshake: the sequencer presents a request with bus_ADS_n=0; it is
  // accepted in IDLE, and the sequencer holds its microinstruction while
  // stall=1, advancing on the edge that leaves END.
  assign req    = ~bus_ADS_n;
  assign accept = (state_q == IDLE) & req;

`ifdef SCMP_BUS_ARB_EN
  localparam BUS_STATE_t REQ_NEXT = ARB;

  scmp_bus_arb u_arb (
    .rst_n       (rst_n),
    .in_arb_i    (state_q == ARB),
    .idle_free_i ((state_q == IDLE) & ~req),
    .ext_ENIN    (ext_ENIN),
    .ext_BREQ    (ext_BREQ),
    .ext_ENOUT   (ext_ENOUT),
    .grant_o     (grant)
  );
`else
  localparam BUS_STATE_t REQ_NEXT = ADDR;
  logic unused_enin;

  assign unused_enin = ext_ENIN;
  assign ext_BREQ    = 1'b0;
  assign ext_ENOUT   = 1'b0;
  assign grant       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req) state_d = REQ_NEXT;
      ARB:  if (grant) state_d = ADDR;
      ADDR: begin
        if (is_rd_q | is_wr_q) begin
          state_d = STRB;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = END;
        end
      end
      // The minimum strobe width runs first; NHOLD only gates the final cycle.
      STRB: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (ext_NHOLD_n) state_d = END;
      end
      END:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ext_a_q   <= '0;
      dout_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      is_rd_q   <= 1'b0;
      is_wr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        ext_a_q <= addr_i[BUS_EXT_A_W-1:0];
        dout_q  <= status_byte(bus_F_H, bus_F_D, bus_F_I, bus_F_R,
                               addr_i[BUS_ADDR_W-1:BUS_EXT_A_W]);
        wdata_q <= wdata_i;
        is_rd_q <= ~bus_RD_n;
        is_wr_q <= ~bus_WR_n & bus_RD_n;
      end
      if ((state_q == ADDR) && is_wr_q) dout_q <= wdata_q;
      if ((state_q == STRB) && (state_d == END) && is_rd_q) rd_data_q <= ext_D_i;
    end
  end

  assign stall = rst_n & (accept | (state_q == ARB) | (state_q == ADDR) | (state_q == STRB));

  assign ext_NADS_n = ~(state_q == ADDR);
  assign ext_NRDS_n = ~((state_q == STRB) & is_rd_q);
  assign ext_NWDS_n = ~((state_q == STRB) & is_wr_q);
  // Write data stays driven through END for hold time.
  assign ext_D_oe   = (state_q == ADDR) | (((state_q == STRB) | (state_q == END)) & is_wr_q);
  assign rd_valid   = (state_q == END) & is_rd_q;

  assign ext_A       = ext_a_q;
  assign ext_D_o     = dout_q;
  assign rd_data     = rd_data_q;
  assign dbg_state_o = state_q;

endmodule
